// File: rtl/ladybird_trap_ctrl.sv
// Trap-entry / MRET sequencer driving the machine-mode CSR write port and PC redirect.
// Optional macro LADYBIRD_TRAP_MTVAL_EN adds the mtval write step (W_TVAL).
module ladybird_trap_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret_valid,
   output logic            busy,
   output logic            csr_valid,
   output logic [2:0]      csr_op,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_data,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam logic [2:0]  FUNCT3_CSRRW = 3'b001;
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_EPC    = 3'd1,
      S_W_CAUSE  = 3'd2,
      S_W_TVAL   = 3'd3,
      S_W_STATUS = 3'd4,
      S_T_REDIR  = 3'd5,
      S_R_STATUS = 3'd6,
      S_R_REDIR  = 3'd7
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [2:0]      op_q;

   // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
   function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] st);
      logic [XLEN-1:0] r;
      r        = st;
      r[7]     = st[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // MRET: MIE <= MPIE, MPIE <= 1, MPP stays M on an M-only hart.
   function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] st);
      logic [XLEN-1:0] r;
      r        = st;
      r[3]     = st[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // Vectored mode only applies to interrupts; modes 2/3 behave as direct.
   function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                   input logic [XLEN-1:0] cause);
      logic [XLEN-1:0] base;
      base = {tvec[XLEN-1:2], 2'b00};
      if ((tvec[1:0] == 2'b01) && cause[XLEN-1]) begin
         return base + {cause[XLEN-3:0], 2'b00};
      end else begin
         return base;
      end
   endfunction

`ifdef LADYBIRD_TRAP_MTVAL_EN
   logic [XLEN-1:0] tval_q, tval_d;
`else
   logic tval_unused_s;
   assign tval_unused_s = ^trap_tval;
`endif

   // State and latched trap context.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cause_q <= '0;
         pc_q    <= '0;
`ifdef LADYBIRD_TRAP_MTVAL_EN
         tval_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
`ifdef LADYBIRD_TRAP_MTVAL_EN
         tval_q  <= tval_d;
`endif
      end
   end

   // csr_op reads 0 while in reset and CSRRW afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= 3'b000;
      end else begin
         op_q <= FUNCT3_CSRRW;
      end
   end

   // Next-state: requests only sampled in IDLE, trap beats mret.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      pc_d    = pc_q;
`ifdef LADYBIRD_TRAP_MTVAL_EN
      tval_d  = tval_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (trap_valid) begin
               state_d = S_W_EPC;
               cause_d = trap_cause;
               pc_d    = trap_pc;
`ifdef LADYBIRD_TRAP_MTVAL_EN
               tval_d  = trap_tval;
`endif
            end else if (mret_valid) begin
               state_d = S_R_STATUS;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_W_EPC:    state_d = S_W_CAUSE;
`ifdef LADYBIRD_TRAP_MTVAL_EN
         S_W_CAUSE:  state_d = S_W_TVAL;
         S_W_TVAL:   state_d = S_W_STATUS;
`else
         S_W_CAUSE:  state_d = S_W_STATUS;
`endif
         S_W_STATUS: state_d = S_T_REDIR;
         S_T_REDIR:  state_d = S_IDLE;
         S_R_STATUS: state_d = S_R_REDIR;
         S_R_REDIR:  state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; RMW data and targets use csr_rdata of the same cycle.
   always_comb begin
      busy           = 1'b1;
      csr_valid      = 1'b0;
      csr_addr       = 12'h000;
      csr_data       = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_W_EPC: begin
            csr_valid = 1'b1;
            csr_addr  = CSR_MEPC;
            csr_data  = {pc_q[XLEN-1:2], 2'b00};
         end
         S_W_CAUSE: begin
            csr_valid = 1'b1;
            csr_addr  = CSR_MCAUSE;
            csr_data  = cause_q;
         end
`ifdef LADYBIRD_TRAP_MTVAL_EN
         S_W_TVAL: begin
            csr_valid = 1'b1;
            csr_addr  = CSR_MTVAL;
            csr_data  = tval_q;
         end
`endif
         S_W_STATUS: begin
            csr_valid = 1'b1;
            csr_addr  = CSR_MSTATUS;
            csr_data  = trap_mstatus(csr_rdata);
         end
         S_T_REDIR: begin
            csr_addr       = CSR_MTVEC;
            redirect_valid = 1'b1;
            redirect_pc    = trap_target(csr_rdata, cause_q);
         end
         S_R_STATUS: begin
            csr_valid = 1'b1;
            csr_addr  = CSR_MSTATUS;
            csr_data  = mret_mstatus(csr_rdata);
         end
         S_R_REDIR: begin
            csr_addr       = CSR_MEPC;
            redirect_valid = 1'b1;
            redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign csr_op = op_q;

endmodule

// File: tb/tb_ladybird_trap_ctrl.sv
// Self-checking bench for ladybird_trap_ctrl: CSR-file model plus per-cycle expected-output queue.
module tb_ladybird_trap_ctrl;
   localparam int XLEN = 32;
`ifdef LADYBIRD_TRAP_MTVAL_EN
   localparam int TRAP_LAT = 5;
`else
   localparam int TRAP_LAT = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        trap_valid, mret_valid;
   logic [31:0] trap_cause, trap_pc, trap_tval;
   logic        busy, csr_valid, redirect_valid;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_data, csr_rdata, redirect_pc;

   ladybird_trap_ctrl #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .trap_tval(trap_tval), .mret_valid(mret_valid),
      .busy(busy), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_data(csr_data), .csr_rdata(csr_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   // CSR file model
   logic [31:0] m_status = 32'h0, m_tvec = 32'h0, m_epc = 32'h0, m_cause = 32'h0, m_tval = 32'h0;
   logic        pre_en = 1'b0;
   logic [11:0] pre_addr = 12'h0;
   logic [31:0] pre_val = 32'h0;

   always_comb begin
      case (csr_addr)
         12'h300: csr_rdata = m_status;
         12'h305: csr_rdata = m_tvec;
         12'h341: csr_rdata = m_epc;
         12'h342: csr_rdata = m_cause;
         12'h343: csr_rdata = m_tval;
         default: csr_rdata = 32'h0;
      endcase
   end

   logic        wr_en;
   logic [11:0] wr_addr;
   logic [31:0] wr_val;
   assign wr_en   = csr_valid | pre_en;
   assign wr_addr = csr_valid ? csr_addr : pre_addr;
   assign wr_val  = csr_valid ? csr_data : pre_val;

   always @(posedge clk) begin
      if (wr_en) begin
         case (wr_addr)
            12'h300: m_status <= wr_val;
            12'h305: m_tvec   <= wr_val;
            12'h341: m_epc    <= wr_val;
            12'h342: m_cause  <= wr_val;
            12'h343: m_tval   <= wr_val;
            default: ;
         endcase
      end
   end

   typedef struct packed {
      logic        busy;
      logic        cv;
      logic [11:0] addr;
      logic [31:0] data;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   exp_t q[$];
   exp_t e_c, a_c;
   int   checks = 0, failures = 0;
   bit   chk_en = 1'b0;
   int   cyc = 0, n_redir = 0, redir_cyc = -100, busy_cnt = 0;
   logic [31:0] last_rpc = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle compare against the expected queue; an empty queue means idle.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (q.size() > 0) e_c = q.pop_front();
         else              e_c = '0;
         a_c = {busy, csr_valid, csr_addr, csr_data, redirect_valid, redirect_pc};
         checks++;
         if (a_c !== e_c) begin
            failures++;
            $display("FAIL cycle%0d: got busy=%b cv=%b addr=%h data=%h rv=%b rpc=%h want busy=%b cv=%b addr=%h data=%h rv=%b rpc=%h",
                     cyc, a_c.busy, a_c.cv, a_c.addr, a_c.data, a_c.rv, a_c.rpc,
                     e_c.busy, e_c.cv, e_c.addr, e_c.data, e_c.rv, e_c.rpc);
         end
         if (csr_valid) begin
            checks++;
            if (csr_op !== 3'b001) begin
               failures++;
               $display("FAIL csr_op: got %b want 001", csr_op);
            end
         end
      end
      if (!rst && redirect_valid) begin
         n_redir++;
         redir_cyc = cyc;
         last_rpc  = redirect_pc;
      end
      if (!rst && busy) busy_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic chk_zero(input string name);
      checks++;
      if ({busy, csr_valid, csr_addr, csr_data, csr_op, redirect_valid, redirect_pc} !== '0) begin
         failures++;
         $display("FAIL %s: outputs not zero busy=%b cv=%b addr=%h data=%h op=%b rv=%b rpc=%h",
                  name, busy, csr_valid, csr_addr, csr_data, csr_op, redirect_valid, redirect_pc);
      end
   endtask

   function automatic exp_t mk(input logic b, input logic cv, input logic [11:0] a,
                               input logic [31:0] d, input logic rv, input logic [31:0] rpc);
      exp_t e;
      e = {b, cv, a, d, rv, rpc};
      return e;
   endfunction

   task automatic preset(input logic [11:0] a, input logic [31:0] v);
      pre_en = 1'b1; pre_addr = a; pre_val = v;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic wait_done(input string name, input int acc, input int lat, input int redir0);
      int n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() > 0) begin
         failures++;
         $display("FAIL %s_timeout: %0d expected cycles left, want 0", name, q.size());
         q.delete();
      end
      chk({name, "_latency"}, redir_cyc - acc + 1, lat);
      chk({name, "_nredir"}, n_redir - redir0, 1);
   endtask

   task automatic do_trap(input string name, input logic [31:0] cause, input logic [31:0] pc,
                          input logic [31:0] tval, input bit also_mret, input bit pulse);
      int acc, r0;
      logic [31:0] st, base, tgt;
      r0 = n_redir;
      trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval; mret_valid = also_mret;
      @(posedge clk); #1;
      acc = cyc;
      trap_valid = 1'b0; mret_valid = 1'b0;
      trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
      st = m_status;
      st[7] = m_status[3];
      st[3] = 1'b0;
      st[12:11] = 2'b11;
      base = m_tvec & 32'hFFFF_FFFC;
      if (m_tvec[1:0] == 2'd1 && cause[31]) tgt = base + (cause & 32'h7FFF_FFFF) * 32'd4;
      else                                  tgt = base;
      q.push_back(mk(1'b1, 1'b1, 12'h341, pc & 32'hFFFF_FFFC, 1'b0, 32'h0));
      q.push_back(mk(1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0));
`ifdef LADYBIRD_TRAP_MTVAL_EN
      q.push_back(mk(1'b1, 1'b1, 12'h343, tval, 1'b0, 32'h0));
`endif
      q.push_back(mk(1'b1, 1'b1, 12'h300, st, 1'b0, 32'h0));
      q.push_back(mk(1'b1, 1'b0, 12'h305, 32'h0, 1'b1, tgt));
      if (pulse) begin
         @(posedge clk); #1;
         trap_valid = 1'b1; trap_cause = 32'h5; trap_pc = 32'h1234; mret_valid = 1'b1;
         @(posedge clk); #1;
         trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; mret_valid = 1'b0;
      end
      wait_done(name, acc, TRAP_LAT, r0);
   endtask

   task automatic do_mret(input string name);
      int acc, r0;
      logic [31:0] st;
      r0 = n_redir;
      mret_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      busy_cnt = 0;
      mret_valid = 1'b0;
      st = m_status;
      st[3] = m_status[7];
      st[7] = 1'b1;
      st[12:11] = 2'b11;
      q.push_back(mk(1'b1, 1'b1, 12'h300, st, 1'b0, 32'h0));
      q.push_back(mk(1'b1, 1'b0, 12'h341, 32'h0, 1'b1, m_epc & 32'hFFFF_FFFC));
      wait_done(name, acc, 2, r0);
      chk({name, "_busy_cycles"}, busy_cnt, 2);
   endtask

   initial begin
      int r0;
      logic [31:0] tval_want;
      rst = 1'b1;
      trap_valid = 1'b0; mret_valid = 1'b0;
      trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
      #12;
      chk_zero("reset_state");
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;

      preset(12'h300, 32'h0000_0008);
      preset(12'h305, 32'h8000_0100);
      do_trap("trap_basic", 32'h2, 32'h8000_0046, 32'h0000_DEAD, 1'b0, 1'b0);
      chk("basic_mepc", m_epc, 32'h8000_0044);
      chk("basic_mcause", m_cause, 32'h0000_0002);
      chk("basic_mstatus", m_status, 32'h0000_1880);
`ifdef LADYBIRD_TRAP_MTVAL_EN
      tval_want = 32'h0000_DEAD;
`else
      tval_want = 32'h0;
`endif
      chk("basic_mtval", m_tval, tval_want);
      chk("basic_rpc", last_rpc, 32'h8000_0100);

      preset(12'h305, 32'h8000_0101);
      do_trap("trap_vec_irq", 32'h8000_0007, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
      chk("vec_irq_rpc", last_rpc, 32'h8000_011C);
      do_trap("trap_vec_exc", 32'h0000_0007, 32'h0000_0104, 32'h0, 1'b0, 1'b0);
      chk("vec_exc_rpc", last_rpc, 32'h8000_0100);
      preset(12'h305, 32'h8000_0203);
      do_trap("trap_mode3", 32'h8000_0003, 32'h0000_0108, 32'h7, 1'b0, 1'b0);
      chk("mode3_rpc", last_rpc, 32'h8000_0200);

      preset(12'h300, 32'h0000_1880);
      preset(12'h341, 32'h8000_0044);
      do_mret("mret");
      chk("mret_mstatus", m_status, 32'h0000_1888);
      chk("mret_rpc", last_rpc, 32'h8000_0044);

      preset(12'h305, 32'h8000_0101);
      do_trap("trap_and_mret", 32'h3, 32'h0000_0200, 32'h11, 1'b1, 1'b0);
      chk("both_mstatus", m_status, 32'h0000_1880);
      do_trap("trap_pulse_busy", 32'hB, 32'h0000_0300, 32'h22, 1'b0, 1'b1);

      // Reset in the middle of a trap sequence.
      chk_en = 1'b0;
      r0 = n_redir;
      preset(12'h342, 32'h0000_00AA);
      trap_valid = 1'b1; trap_cause = 32'h4; trap_pc = 32'h0000_0400; trap_tval = 32'h9;
      @(posedge clk); #1;
      trap_valid = 1'b0;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1 chk_zero("reset_mid_seq");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_redirect", n_redir - r0, 0);
      chk("rst_mepc_kept", m_epc, 32'h0000_0400);
      chk("rst_mcause_untouched", m_cause, 32'h0000_00AA);
      chk_en = 1'b1;
      do_trap("trap_after_rst", 32'h4, 32'h0000_0400, 32'h9, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         preset(12'h305, $urandom);
         preset(12'h300, $urandom);
         do_trap("trap_rand", $urandom, $urandom, $urandom, 1'b0, 1'b0);
         preset(12'h341, $urandom);
         do_mret("mret_rand");
      end

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ladybird_trap_ctrl.md
Name: ladybird_trap_ctrl

Overview:
Trap/return sequencer for the machine-mode CSR file.
- On a synchronous exception or interrupt, it drives the CSR file's single write port through the trap-entry CSR updates, then issues a PC redirect to the mtvec target.
- On MRET, it restores mstatus and redirects to mepc.
- Sits between the execute/commit stage and the CSR file. It owns the CSR port while busy; the core stalls on busy.

Parameters:
XLEN, 32, datapath / CSR width (32 only supported)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
trap_valid  in  1  trap request, sampled only in IDLE
trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
trap_pc  in  XLEN  PC of faulting/interrupted instruction
trap_tval  in  XLEN  mtval value
mret_valid  in  1  MRET request, sampled only in IDLE
busy  out  1  sequence in progress; core must hold requests
csr_valid  out  1  CSR write strobe (ladybird_csr i_valid)
csr_op  out  3  always FUNCT3_CSRRW
csr_addr  out  12  CSR address; also selects read data
csr_data  out  XLEN  CSR write data
csr_rdata  in  XLEN  CSR read data for csr_addr (combinational)
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  XLEN  redirect target, valid with redirect_valid

Behaviour:
- Reset: rst asserted asynchronously forces IDLE, clears latched cause/pc/tval, and drives all outputs to 0 (csr_op also 0).
- Reset mid-sequence: abandons the sequence immediately. CSR writes already issued are not undone, and no redirect is issued.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, T_REDIR, R_STATUS, R_REDIR.
- IDLE:
  - busy=0, csr_valid=0, csr_addr=0.
  - trap_valid=1: latch trap_cause/pc/tval, go to W_EPC.
  - Else mret_valid=1: go to R_STATUS.
  - Both asserted: trap wins and the mret is dropped (the core must re-present it).
- Requests while not in IDLE are ignored.
- busy=1 in every state other than IDLE.
- W_EPC: csr_valid=1, addr 0x341, data = latched pc with bits[1:0] cleared -> W_CAUSE.
- W_CAUSE: csr_valid=1, addr 0x342, data = latched cause -> W_TVAL.
- W_TVAL: csr_valid=1, addr 0x343, data = latched tval -> W_STATUS.
- W_STATUS (read-modify-write in one cycle):
  - csr_valid=1, addr 0x300.
  - data = csr_rdata with MPIE(bit7) = csr_rdata.MIE(bit3), MIE = 0, MPP(bits12:11) = 2'b11; all other bits pass through.
  - -> T_REDIR.
- T_REDIR:
  - csr_valid=0, addr 0x305 (mtvec read), redirect_valid=1 -> IDLE.
  - base = csr_rdata with bits[1:0] cleared.
  - If mode = csr_rdata[1:0] = 1 and cause bit XLEN-1 = 1: redirect_pc = base + (cause[XLEN-2:0] << 2), mod 2^XLEN, wrap ignored.
  - Otherwise redirect_pc = base. Modes 2 and 3 are treated as direct.
- R_STATUS:
  - csr_valid=1, addr 0x300.
  - data = csr_rdata with MIE = csr_rdata.MPIE, MPIE = 1, MPP = 2'b11 (M-only hart).
  - -> R_REDIR.
- R_REDIR: csr_valid=0, addr 0x341, redirect_valid=1, redirect_pc = csr_rdata with bits[1:0] cleared -> IDLE.
- Latency and throughput:
  - Trap accepted at edge E: redirect_valid is high in cycle E+5.
  - MRET accepted at edge E: redirect_valid is high in cycle E+2.
  - A new request is accepted at the edge that ends the redirect cycle (back-to-back).
- csr_data = 0 whenever csr_valid = 0.

Optional Feature:
LADYBIRD_TRAP_MTVAL_EN
- Defined: W_TVAL present; trap latency 5.
- Undefined: W_TVAL removed (W_CAUSE -> W_STATUS), trap_tval is unused and not latched, and trap latency is 4.

Test Plan:
- mstatus=0x00000008, mtvec=0x80000100, trap cause=2, pc=0x80000046, tval=0xDEAD:
  - writes 0x341=0x80000044, 0x342=2, 0x343=0xDEAD, 0x300=0x00001880, in consecutive cycles.
  - redirect_pc=0x80000100 in cycle E+5.
- mtvec=0x80000101, cause=0x80000007: redirect_pc=0x8000011C. Same mtvec with cause=7 (exception): 0x80000100.
- mstatus=0x00001880, mepc=0x80000044, mret:
  - 0x300 written with 0x00001888.
  - redirect_pc=0x80000044 at E+2; busy high exactly 2 cycles.
- trap_valid and mret_valid both high in IDLE: trap sequence only, no mstatus MRET write. trap_valid pulsed during busy: ignored, exactly one redirect.
- rst asserted asynchronously during W_CAUSE: outputs 0 immediately, no redirect. First trap after release completes normally.
- Build without LADYBIRD_TRAP_MTVAL_EN: no write to 0x343, redirect at E+4.
